// File: rtl/lsu_ctrl_mo_if.sv
// lsu_ctrl_mo_if: AGU/DTCM/write-back bus bundle; master = LSU control view, slave = environment view
interface lsu_ctrl_mo_if #(
  parameter int DW = 32,
  parameter int AW = 16,
  parameter int TW = 1
);
  logic          agu_cmd_valid;
  logic          agu_cmd_ready;
  logic          agu_cmd_read;
  logic [1:0]    agu_cmd_size;
  logic          agu_cmd_usign;
  logic [AW-1:0] agu_cmd_addr;
  logic [DW-1:0] agu_cmd_wdata;
  logic [TW-1:0] agu_cmd_itag;
  logic          agu_rsp_valid;
  logic          agu_rsp_ready;
  logic          dtcm_cmd_valid;
  logic          dtcm_cmd_ready;
  logic          dtcm_cmd_read;
  logic [AW-1:0] dtcm_cmd_addr;
  logic [DW-1:0] dtcm_cmd_wdata;
  logic [DW/8-1:0] dtcm_cmd_wmask;
  logic          dtcm_rsp_valid;
  logic          dtcm_rsp_ready;
  logic [DW-1:0] dtcm_rsp_rdata;
  logic          lsu_o_valid;
  logic          lsu_o_ready;
  logic [DW-1:0] lsu_o_wbck_data;
  logic [TW-1:0] lsu_o_wbck_itag;
  logic          lsu_o_excp_valid;
  logic [TW-1:0] lsu_o_excp_itag;
  modport master (
    input  agu_cmd_valid, agu_cmd_read, agu_cmd_size, agu_cmd_usign, agu_cmd_addr, agu_cmd_wdata, agu_cmd_itag,
    output agu_cmd_ready, agu_rsp_valid,
    input  agu_rsp_ready,
    output dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask,
    input  dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata,
    output dtcm_rsp_ready,
    output lsu_o_valid, lsu_o_wbck_data, lsu_o_wbck_itag, lsu_o_excp_valid, lsu_o_excp_itag,
    input  lsu_o_ready
  );
  modport slave (
    output agu_cmd_valid, agu_cmd_read, agu_cmd_size, agu_cmd_usign, agu_cmd_addr, agu_cmd_wdata, agu_cmd_itag,
    input  agu_cmd_ready, agu_rsp_valid,
    output agu_rsp_ready,
    input  dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask,
    output dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata,
    input  dtcm_rsp_ready,
    input  lsu_o_valid, lsu_o_wbck_data, lsu_o_wbck_itag, lsu_o_excp_valid, lsu_o_excp_itag,
    output lsu_o_ready
  );
endinterface

// File: rtl/lsu_ctrl_mo.sv
// lsu_ctrl_mo: multi-outstanding LSU control (clk, rst_n, bus: master modport of lsu_ctrl_mo_if; misalign check under LSU_MISALIGN_CHK_EN)
module lsu_ctrl_mo #(
  parameter int DW   = 32,
  parameter int AW   = 16,
  parameter int TW   = 1,
  parameter int OUTS = 2
) (
  input logic clk,
  input logic rst_n,
  lsu_ctrl_mo_if.master bus
);
  localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int CW = $clog2(OUTS + 1);
  typedef struct packed {
    logic [TW-1:0] itag;
    logic          read;
    logic [1:0]    size;
    logic          usign;
    logic [1:0]    lo;
  } ent_t;
  ent_t            fifo_q [OUTS];
  logic [PW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full, empty, mis, push, pop, go;
  ent_t            head;
  logic [DW-1:0]   wdata_s, sh, ext;
  logic [DW/8-1:0] wmask_s;
  logic [1:0]      sz, lo;
  assign sz    = bus.agu_cmd_size;
  assign lo    = bus.agu_cmd_addr[1:0];
  assign full  = cnt_q == CW'(OUTS);
  assign empty = cnt_q == '0;
  assign head  = fifo_q[rptr_q];
`ifdef LSU_MISALIGN_CHK_EN
  logic          excp_q;
  logic [TW-1:0] excp_itag_q;
  assign mis = (sz == 2'd1 & lo[0]) | (sz[1] & lo != 2'd0);
  // misaligned commands wait for an empty FIFO so the exception stays in program order
  assign bus.agu_cmd_ready = mis ? empty : bus.dtcm_cmd_ready & ~full;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      excp_q      <= 1'b0;
      excp_itag_q <= '0;
    end else begin
      excp_q      <= bus.agu_cmd_valid & mis & empty;
      excp_itag_q <= bus.agu_cmd_itag;
    end
  assign bus.lsu_o_excp_valid = excp_q;
  assign bus.lsu_o_excp_itag  = excp_q ? excp_itag_q : '0;
`else
  assign mis = 1'b0;
  assign bus.agu_cmd_ready    = bus.dtcm_cmd_ready & ~full;
  assign bus.lsu_o_excp_valid = 1'b0;
  assign bus.lsu_o_excp_itag  = '0;
`endif
  assign bus.dtcm_cmd_valid = bus.agu_cmd_valid & ~full & ~mis;
  assign push = bus.agu_cmd_valid & bus.agu_cmd_ready & ~mis;
  assign go   = ~empty & bus.agu_rsp_ready & (~head.read | bus.lsu_o_ready);
  assign pop  = bus.dtcm_rsp_valid & go;
  always_comb begin
    wdata_s = sz == 2'd0 ? {4{bus.agu_cmd_wdata[7:0]}} : sz == 2'd1 ? {2{bus.agu_cmd_wdata[15:0]}} : bus.agu_cmd_wdata;
    wmask_s = bus.agu_cmd_read ? 4'b0000 : sz == 2'd0 ? 4'b0001 << lo : sz == 2'd1 ? 4'b0011 << {lo[1], 1'b0} : 4'hF;
    sh      = head.size == 2'd0 ? bus.dtcm_rsp_rdata >> {head.lo, 3'b000} :
              head.size == 2'd1 ? bus.dtcm_rsp_rdata >> {head.lo[1], 4'b0000} : bus.dtcm_rsp_rdata;
    ext     = head.size == 2'd0 ? {{24{~head.usign & sh[7]}}, sh[7:0]} :
              head.size == 2'd1 ? {{16{~head.usign & sh[15]}}, sh[15:0]} : sh;
    wptr_d  = push ? (wptr_q == PW'(OUTS - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d  = pop ? (rptr_q == PW'(OUTS - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
  end
  // command data is gated so the bus reads as zero whenever no command is offered
  assign bus.dtcm_cmd_read   = bus.dtcm_cmd_valid & bus.agu_cmd_read;
  assign bus.dtcm_cmd_addr   = bus.dtcm_cmd_valid ? {bus.agu_cmd_addr[AW-1:2], 2'b00} : '0;
  assign bus.dtcm_cmd_wdata  = bus.dtcm_cmd_valid ? wdata_s : '0;
  assign bus.dtcm_cmd_wmask  = bus.dtcm_cmd_valid ? wmask_s : '0;
  assign bus.dtcm_rsp_ready  = go;
  assign bus.agu_rsp_valid   = pop;
  assign bus.lsu_o_valid     = pop & head.read;
  assign bus.lsu_o_wbck_data = bus.lsu_o_valid ? ext : '0;
  assign bus.lsu_o_wbck_itag = bus.lsu_o_valid ? head.itag : '0;
  always_ff @(posedge clk)
    if (push) fifo_q[wptr_q] <= '{bus.agu_cmd_itag, bus.agu_cmd_read, sz, bus.agu_cmd_usign, lo};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
endmodule

// File: doc/lsu_ctrl_mo.md
# lsu_ctrl_mo

Parametrised multi-outstanding load/store control unit between the AGU and the DTCM, successor to the single-outstanding LSU control. Accepts up to OUTS in-order memory commands, generates byte lanes and store masks from access size, and tracks each command in an internal tag FIFO. It aligns and extends returning load data and forwards it with its ITAG to the long-pipe write-back, honouring write-back back-pressure.

## Interface
- DW, 32: data width; only 32 is supported.
- AW, 16: DTCM byte-address width.
- TW, 1: ITAG width.
- OUTS, 2: maximum outstanding commands, 1..8.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- agu_cmd_valid / agu_cmd_ready  in/out  1  AGU command handshake.
- agu_cmd_read  in  1  1 = load, 0 = store.
- agu_cmd_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- agu_cmd_usign  in  1  load zero-extends when 1, sign-extends when 0.
- agu_cmd_addr  in  AW  byte address.
- agu_cmd_wdata  in  DW  store data, right-aligned.
- agu_cmd_itag  in  TW  instruction tag.
- agu_rsp_valid / agu_rsp_ready  out/in  1  per-command completion handshake.
- dtcm_cmd_valid / dtcm_cmd_ready  out/in  1  DTCM command handshake.
- dtcm_cmd_read  out  1.
- dtcm_cmd_addr  out  AW  word-aligned: addr with [1:0] forced to 0.
- dtcm_cmd_wdata  out  DW  lane-replicated store data.
- dtcm_cmd_wmask  out  DW/8  byte-enable mask.
- dtcm_rsp_valid / dtcm_rsp_ready  in/out  1  DTCM response handshake.
- dtcm_rsp_rdata  in  DW.
- lsu_o_valid / lsu_o_ready  out/in  1  write-back handshake, loads only.
- lsu_o_wbck_data  out  DW  aligned and extended load data; 0 when lsu_o_valid = 0.
- lsu_o_wbck_itag  out  TW  0 when lsu_o_valid = 0.
- lsu_o_excp_valid  out  1  misaligned-access pulse (macro only; tied 0 otherwise).
- lsu_o_excp_itag  out  TW  tag of the misaligned access.

## Operation
- The tag FIFO has OUTS entries. Each entry holds {itag, read, size, usign, addr[1:0]}.
- The FIFO uses a read pointer, a write pointer, and a count (0..OUTS). Pointers wrap modulo OUTS.
- full = (count == OUTS); empty = (count == 0).
- Issue path:
  - dtcm_cmd_valid = agu_cmd_valid & ~full.
  - agu_cmd_ready = dtcm_cmd_ready & ~full.
  - Push on agu_cmd_valid & agu_cmd_ready.
  - No full-bypass: a pop in the same cycle does not free a slot for that cycle's push.
- Store lanes:
  - Byte: wdata = {4{wdata[7:0]}}; wmask = 4'b0001 << addr[1:0].
  - Half: wdata = {2{wdata[15:0]}}; wmask = 4'b0011 << {addr[1],1'b0}.
  - Word: wdata unchanged; wmask = 4'hF.
  - Loads: wmask = 0.
- Response path (head = FIFO entry at the read pointer):
  - go = ~empty & agu_rsp_ready & (~head.read | lsu_o_ready).
  - dtcm_rsp_ready = go.
  - agu_rsp_valid = dtcm_rsp_valid & go.
  - Pop on dtcm_rsp_valid & go.
  - lsu_o_valid = dtcm_rsp_valid & go & head.read.
  - Store responses pop without write-back.
- Load alignment: shift rdata right by 8·head.addr[1:0] (byte) or 16·head.addr[1] (half). Then zero-extend or sign-extend to DW according to head.usign.
- Simultaneous push and pop: count holds; both pointers advance.
- A DTCM response while empty is not acknowledged (dtcm_rsp_ready = 0). This is a protocol violation; the bench must flag it.

## Timing
- Issue is combinational pass-through in the same cycle as the AGU handshake.
- DTCM latency is arbitrary (≥1 cycle); responses are in order.
- Write-back is combinational from dtcm_rsp_valid, gated by go.
- Reset, asynchronous: count = 0, both pointers = 0, excp register = 0.
- Outputs after reset:
  - All ready/valid outputs are 0, except agu_cmd_ready, which equals dtcm_cmd_ready.
  - All data outputs are 0.
- Reset mid-operation discards all outstanding entries. The DTCM must be reset together with this block.

## Configuration
- LSU_MISALIGN_CHK_EN defined:
  - A command is misaligned when (half & addr[0]) or (word & addr[1:0] != 0).
  - A misaligned command is never forwarded (dtcm_cmd_valid = 0) and never pushed.
  - Its agu_cmd_ready = empty. This waits for the FIFO to drain so that ordering is preserved.
  - On its handshake, lsu_o_excp_valid and lsu_o_excp_itag are registered. They pulse high for exactly one cycle, in the next cycle.
- LSU_MISALIGN_CHK_EN undefined:
  - No check is made.
  - The address is forwarded word-aligned and lanes are computed from the low bits as above.
  - lsu_o_excp_valid = 0 and lsu_o_excp_itag = 0.

## Test plan
- Load byte, addr 0x0003, usign 0, DTCM rdata 0x80xxxxxx, one cycle later -> wmask 0; lsu_o_wbck_data 0xFFFFFF80; itag returned.
- Store half, addr 0x0002, wdata 0x0000BEEF -> dtcm_cmd_wdata 0xBEEFBEEF; wmask 4'b1100; agu_rsp_valid = 1 and lsu_o_valid = 0 on the response.
- OUTS = 2, three back-to-back loads with the DTCM stalled -> third command's agu_cmd_ready = 0 until the first response pops. Itags are written back in issue order.
- lsu_o_ready held 0 for 3 cycles with a load at the head -> dtcm_rsp_ready = 0 for those 3 cycles. Data is delivered on the first cycle with lsu_o_ready = 1.
- Push and pop in the same cycle at count = 1, then assert rst_n low mid-stream -> count stays 1 across the push/pop; after reset, count = 0 and lsu_o_valid = 0.
- With LSU_MISALIGN_CHK_EN, word load at 0x0001 while one load is outstanding -> agu_cmd_ready = 0 until the FIFO is empty. lsu_o_excp_valid then pulses for 1 cycle with its itag; no DTCM command is issued.
